tx_sched_arbiter: RTL and testbench
===================================

// Module: tx_sched_arbiter
// PURPOSE
//  Round-robin scheduler sharing one serial transmitter (8-bit data, start pulse, 4-bit frame cnt)
//  among NREQ byte sources. Captures one requester's byte, issues a single-cycle start,
//  tracks frame completion via the transmitter's cnt, enforces an inter-frame gap, then re-arbitrates.
//  Sits between producer logic and the transmitter; transmitter output path is unchanged.
// PARAMETERS
//  NREQ      4    number of requesters (2..4)
//  IDW       2    owner index width; NREQ <= 2**IDW
//  FRAME_END 11   transmitter cnt value marking end of frame
//  GAP       2    idle cycles between frame end and next launch (0 allowed)
//  TIMEOUT   64   WAIT watchdog limit in cycles (only with TXS_TIMEOUT_EN)
// PORTS
//  clk       in   1        system clock, all logic on posedge
//  rst       in   1        synchronous active-high reset
//  req       in   NREQ     per-requester request; hold high with stable data until gnt
//  req_data  in   8*NREQ   byte i at [8*i+7:8*i]
//  gnt       out  NREQ     one-hot, 1-cycle pulse: byte of that requester captured
//  tx_start  out  1        to transmitter start; 1-cycle pulse
//  tx_data   out  8        to transmitter data; held stable from launch until frame done
//  tx_cnt    in   4        from transmitter cnt
//  busy      out  1        1 whenever state != IDLE
//  owner     out  IDW      index of current granted requester; valid while busy
//  err       out  1        1-cycle timeout pulse (0 constant without TXS_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, tx_start=0, tx_data=0, busy=0, owner=0,
//   err=0, rr pointer=0 (requester 0 highest priority), gap counter=0, end-detect reg=0.
//  Reset mid-frame: controller returns to IDLE immediately; transmitter is not signalled.
//   Transmitter shares the same rst in the system.
//  States: IDLE -> WAIT -> GAP -> IDLE (GAP skipped when GAP=0).
//  IDLE: if |req at posedge: pick first asserted index starting at rr pointer, wrapping.
//   Same edge: gnt[i]<=1, tx_data<=req_data[i], tx_start<=1, owner<=i, rr<=i+1 mod NREQ,
//   state<=WAIT. Latency req->gnt/tx_start: 1 cycle. No req: all pulses 0.
//  WAIT: gnt, tx_start return to 0 after one cycle. Frame done = rising edge of
//   (tx_cnt==FRAME_END), i.e., compare true now and registered compare false last cycle.
//   A cnt already parked at FRAME_END on entry is not done. On done: GAP (or IDLE if GAP=0).
//   req changes are ignored.
//  GAP: count GAP cycles, then IDLE. First new launch edge = frame-done edge + GAP + 1.
//  Request held after its gnt is a new request; the rr pointer gives the other requesters
//   priority first. One requester alone may send back-to-back frames.
//  Simultaneous requests: strict rotation, no requester starves (worst wait NREQ-1 frames).
//  Requester dropping req before gnt: no capture, no gnt. Arbitration uses req at the IDLE edge.
//  tx_data stays registered until next launch. owner holds after return to IDLE.
// CONFIGURATION
//  TXS_TIMEOUT_EN defined: WAIT cycle counter cleared on entry. Reaching TIMEOUT without
//   frame done: err pulses 1 cycle, state->GAP, owner's byte dropped (no retry).
//  Not defined: no counter, err tied 0, WAIT waits indefinitely.
// TESTING
//  1 single: req=4'b0010, data1=8'h43 -> next edge gnt=0010, tx_start 1 cycle, tx_data=43,
//    busy until rising tx_cnt==11, +GAP+1 -> IDLE.
//  2 all four req at once, data 41..44 -> frames sent in order 0,1,2,3, one gnt each,
//    tx_start spacing = frame length + GAP + 1.
//  3 req0 held continuously with req2 -> alternating owners 0,2,0,2.
//  4 tx_cnt parked at 11 when launch occurs -> no premature done; done only on next 0->11 edge.
//  5 rst asserted in WAIT -> next edge all outputs 0, rr=0; after release req=4'b1001 -> owner 0.
//  6 TXS_TIMEOUT_EN, tx_cnt stuck at 0 -> err pulse exactly TIMEOUT cycles after WAIT entry,
//    then GAP, IDLE. Without macro: busy stays 1, err 0.

Source files
------------

// File: rtl/tx_sched_arbiter.sv
// tx_sched_arbiter: round-robin launcher sharing one serial transmitter among NREQ byte sources.
// Optional WAIT watchdog with err pulse is enabled by defining TXS_TIMEOUT_EN.
module tx_sched_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int FRAME_END = 11,
  parameter int GAP       = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic [3:0]        tx_cnt,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;
  state_t         r_state;
  logic [IDW-1:0] r_rr;
  logic [IDW-1:0] w_pick;
  logic [7:0]     r_gap;
  logic           r_end_q;
  logic           w_eq;
  logic           w_done;
  logic           w_to;
  state_t         w_after;
  assign w_eq    = tx_cnt == 4'(FRAME_END);
  assign w_done  = w_eq & ~r_end_q;
  assign w_after = (GAP == 0) ? S_IDLE : S_GAP;
  assign busy    = r_state != S_IDLE;
  // Scan downward so the lowest offset from the rr pointer wins.
  always_comb begin
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(r_rr) + k) % NREQ]) w_pick = IDW'((int'(r_rr) + k) % NREQ);
  end
`ifdef TXS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait;
  logic          r_err;
  assign w_to = (r_state == S_WAIT) && (r_wait == TW'(TIMEOUT - 1));
  assign err  = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= w_to & ~w_done;
      r_wait <= (r_state == S_WAIT) ? r_wait + 1'b1 : '0;
    end
  end
`else
  assign w_to = 1'b0;
  assign err  = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      gnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      r_rr     <= '0;
      r_gap    <= '0;
      r_end_q  <= 1'b0;
    end else begin
      r_end_q  <= w_eq;
      gnt      <= '0;
      tx_start <= 1'b0;
      case (r_state)
        S_IDLE: if (|req) begin
          gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          tx_data  <= req_data[8*int'(w_pick) +: 8];
          tx_start <= 1'b1;
          owner    <= w_pick;
          r_rr     <= IDW'((int'(w_pick) + 1) % NREQ);
          r_state  <= S_WAIT;
        end
        S_WAIT: if (w_done || w_to) begin
          r_state <= w_after;
          r_gap   <= '0;
        end
        S_GAP: begin
          r_gap   <= r_gap + 1'b1;
          r_state <= (r_gap == 8'(GAP - 1)) ? S_IDLE : S_GAP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_sched_arbiter.sv
// tb_tx_sched_arbiter: directed checks of launch, rotation, end detection, reset and watchdog.
module tb_tx_sched_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  tx_cnt;
  logic        busy;
  logic [1:0]  owner;
  logic        err;
  int total = 0;
  int bad   = 0;
  tx_sched_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_cnt(tx_cnt), .busy(busy),
    .owner(owner), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drive a short frame ending in a 0->11 edge, then walk through the 2-cycle gap.
  task automatic finish_frame(input string tag);
    tx_cnt = 4'd3;
    tick();
    tx_cnt = 4'd11;
    tick();
    chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
    tx_cnt = 4'd0;
    tick();
    chk({tag, "_gap2_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_cnt = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    // single requester 1
    req = 4'b0010; req_data = 32'h0000_4300;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h43);
    chk("t1_owner", 32'(owner), 32'd1);
    req = '0;
    tick();
    chk("t1_start_off", 32'(tx_start), 32'd0);
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    finish_frame("t1");
    chk("t1_data_hold", 32'(tx_data), 32'h43);
    chk("t1_owner_hold", 32'(owner), 32'd1);
    // all four at once after reset: strict order 0..3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; req_data = 32'h4443_4241;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_gnt", 32'(gnt), 32'(1 << i));
      chk("t2_start", 32'(tx_start), 32'd1);
      chk("t2_data", 32'(tx_data), 32'(8'h41 + i));
      chk("t2_owner", 32'(owner), 32'(i));
      req[i] = 1'b0;
      finish_frame("t2");
    end
    // req0 and req2 held continuously alternate
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_owner", 32'(owner), (i % 2 == 0) ? 32'd0 : 32'd2);
      chk("t3_start", 32'(tx_start), 32'd1);
      finish_frame("t3");
    end
    req = '0;
    // cnt parked at FRAME_END at launch is not a frame end
    tx_cnt = 4'd11; req = 4'b0001;
    tick();
    chk("t4_owner", 32'(owner), 32'd0);
    req = '0;
    tick();
    tick();
    chk("t4_no_early", 32'(busy), 32'd1);
    tx_cnt = 4'd0;
    tick();
    chk("t4_wait", 32'(busy), 32'd1);
    finish_frame("t4");
    // reset in WAIT; rr pointer returns to 0
    req = 4'b0100;
    tick();
    chk("t5_owner", 32'(owner), 32'd2);
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_data", 32'(tx_data), 32'd0);
    chk("t5_owner0", 32'(owner), 32'd0);
    chk("t5_start", 32'(tx_start), 32'd0);
    req = 4'b1001;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h1);
    chk("t5_owner_new", 32'(owner), 32'd0);
    req = '0;
    // cnt stuck at 0 in WAIT
    for (int k = 1; k <= 70; k++) begin
      tick();
`ifdef TXS_TIMEOUT_EN
      chk("t6_err", 32'(err), (k == 64) ? 32'd1 : 32'd0);
`else
      chk("t6_err", 32'(err), 32'd0);
`endif
    end
`ifndef TXS_TIMEOUT_EN
    chk("t6_busy", 32'(busy), 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
